// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared types, op codes and decode helpers for the load/store unit.
package ysyx_22051013_lsu_pkg;

    // LSU control states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Access size codes
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    localparam int LSU_RSP_TIMEOUT = 256;

    // Execute-stage op codes seen by the LSU
    localparam logic [7:0] INST_ADD = 8'h01;
    localparam logic [7:0] INST_LB  = 8'h20;
    localparam logic [7:0] INST_LH  = 8'h21;
    localparam logic [7:0] INST_LW  = 8'h22;
    localparam logic [7:0] INST_LD  = 8'h23;
    localparam logic [7:0] INST_LBU = 8'h24;
    localparam logic [7:0] INST_LHU = 8'h25;
    localparam logic [7:0] INST_LWU = 8'h26;
    localparam logic [7:0] INST_SB  = 8'h28;
    localparam logic [7:0] INST_SH  = 8'h29;
    localparam logic [7:0] INST_SW  = 8'h2A;
    localparam logic [7:0] INST_SD  = 8'h2B;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        logic      is_unsigned;
        lsu_size_e size;
    } lsu_dec_t;

    // Anything that is not a load or store is a pass-through op.
    function automatic lsu_dec_t lsu_decode(input logic [7:0] sel);
        lsu_dec_t d;
        d.is_mem      = 1'b1;
        d.is_store    = 1'b0;
        d.is_unsigned = 1'b0;
        d.size        = SZ_D;
        case (sel)
            INST_LB:  d.size = SZ_B;
            INST_LH:  d.size = SZ_H;
            INST_LW:  d.size = SZ_W;
            INST_LD:  d.size = SZ_D;
            INST_LBU: begin d.size = SZ_B; d.is_unsigned = 1'b1; end
            INST_LHU: begin d.size = SZ_H; d.is_unsigned = 1'b1; end
            INST_LWU: begin d.size = SZ_W; d.is_unsigned = 1'b1; end
            INST_SB:  begin d.size = SZ_B; d.is_store = 1'b1; end
            INST_SH:  begin d.size = SZ_H; d.is_store = 1'b1; end
            INST_SW:  begin d.size = SZ_W; d.is_store = 1'b1; end
            INST_SD:  begin d.size = SZ_D; d.is_store = 1'b1; end
            default:  d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    // An access is misaligned when it would straddle its natural boundary.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [2:0] off);
        logic m;
        case (size)
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            SZ_D:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_if.sv
// Execute, writeback and memory-bus signals of the LSU.
// master = the LSU itself; slave = the surrounding pipeline and memory.
interface ysyx_22051013_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_alu_sel;
    logic [63:0] in_alu_res;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    modport master (
        input  in_valid, in_alu_sel, in_alu_res, in_store_data, in_rd,
        output in_ready,
        output out_valid, out_data, out_rd, out_wen, out_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        output in_valid, in_alu_sel, in_alu_res, in_store_data, in_rd,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_wen, out_err,
        output out_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/ysyx_22051013_lsu_lane.sv
// Byte-lane steering: store data/strobes onto the 64-bit bus and
// load data off it with sign or zero extension. Purely combinational.
module ysyx_22051013_lsu_lane
    import ysyx_22051013_lsu_pkg::*;
(
    input  lsu_size_e   st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_data_i,
    output logic [7:0]  st_wstrb_o,
    output logic [63:0] st_wdata_o,
    input  lsu_size_e   ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    function automatic logic [7:0] store_strb(input lsu_size_e size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] load_extract(input logic [63:0] rdata, input lsu_size_e size,
                                                 input logic [2:0] off, input logic uns);
        logic [63:0] lane;
        logic [63:0] res;
        lane = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    res = uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            SZ_H:    res = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SZ_W:    res = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    // Steer both directions from the current size/offset
    always_comb begin
        st_wstrb_o = store_strb(st_size_i, st_off_i);
        st_wdata_o = st_data_i << {st_off_i, 3'b000};
        ld_data_o  = load_extract(ld_rdata_i, ld_size_i, ld_off_i, ld_unsigned_i);
    end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store unit: one op in flight, IDLE -> REQ -> WAIT -> DONE.
// Non-memory and misaligned ops skip the bus and complete the next cycle.
module ysyx_22051013_lsu
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = LSU_RSP_TIMEOUT
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22051013_lsu_if.master     bus
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

    lsu_state_e  state_q;
    lsu_size_e   size_q;
    logic [2:0]  off_q;
    logic        uns_q;
    logic        store_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        timeout_d;

    logic        mem_req_valid_q, mem_req_wen_q;
    logic [63:0] mem_req_addr_q, mem_req_wdata_q;
    logic [7:0]  mem_req_wstrb_q;
    logic        out_valid_q, out_wen_q, out_err_q;
    logic [63:0] out_data_q;
    logic [4:0]  out_rd_q;

    lsu_dec_t    in_dec;
    logic [7:0]  st_wstrb;
    logic [63:0] st_wdata, ld_data;

    assign in_dec = lsu_decode(bus.in_alu_sel);

    ysyx_22051013_lsu_lane u_lane (
        .st_size_i     (in_dec.size),
        .st_off_i      (bus.in_alu_res[2:0]),
        .st_data_i     (bus.in_store_data),
        .st_wstrb_o    (st_wstrb),
        .st_wdata_o    (st_wdata),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (bus.mem_rsp_rdata),
        .ld_data_o     (ld_data)
    );

    // Response-wait counter: the op times out on the RSP_TIMEOUT-th silent WAIT cycle
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        timeout_d = (cnt_d == CNT_W'(RSP_TIMEOUT));
    end

    // Control FSM with registered bus and writeback outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= LSU_IDLE;
            size_q          <= SZ_B;
            off_q           <= 3'd0;
            uns_q           <= 1'b0;
            store_q         <= 1'b0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_req_addr_q  <= 64'd0;
            mem_req_wdata_q <= 64'd0;
            mem_req_wstrb_q <= 8'd0;
            out_valid_q     <= 1'b0;
            out_wen_q       <= 1'b0;
            out_err_q       <= 1'b0;
            out_data_q      <= 64'd0;
            out_rd_q        <= 5'd0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (bus.in_valid) begin
                        size_q   <= in_dec.size;
                        off_q    <= bus.in_alu_res[2:0];
                        uns_q    <= in_dec.is_unsigned;
                        store_q  <= in_dec.is_store;
                        out_rd_q <= bus.in_rd;
                        if (!in_dec.is_mem) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= bus.in_alu_res;
                            out_wen_q   <= (bus.in_rd != 5'd0);
                            out_err_q   <= 1'b0;
                            state_q     <= LSU_DONE;
                        end else if (lsu_misaligned(in_dec.size, bus.in_alu_res[2:0])) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= 64'd0;
                            out_wen_q   <= 1'b0;
                            out_err_q   <= 1'b1;
                            state_q     <= LSU_DONE;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {bus.in_alu_res[63:3], 3'b000};
                            mem_req_wen_q   <= in_dec.is_store;
                            mem_req_wdata_q <= in_dec.is_store ? st_wdata : 64'd0;
                            mem_req_wstrb_q <= in_dec.is_store ? st_wstrb : 8'd0;
                            state_q         <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= store_q ? 64'd0 : ld_data;
                        out_wen_q   <= !store_q && (out_rd_q != 5'd0);
                        out_err_q   <= 1'b0;
                        state_q     <= LSU_DONE;
                    end else if (timeout_d) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= 64'd0;
                        out_wen_q   <= 1'b0;
                        out_err_q   <= 1'b1;
                        state_q     <= LSU_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LSU_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        state_q     <= LSU_IDLE;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = rst && (state_q == LSU_IDLE);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_wen   = mem_req_wen_q;
    assign bus.mem_req_wdata = mem_req_wdata_q;
    assign bus.mem_req_wstrb = mem_req_wstrb_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_wen       = out_wen_q;
    assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Scoreboard bench for the LSU: expected writeback results are queued when
// an op is issued and compared when the LSU presents them.
module tb_ysyx_22051013_lsu;
    import ysyx_22051013_lsu_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22051013_lsu_if bus();

    ysyx_22051013_lsu #(.RSP_TIMEOUT(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vec_cnt = 0;
    int   miscmp  = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [4:0] rd, input logic wen, input logic err);
        exp_t e;
        e.data = d; e.rd = rd; e.wen = wen; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic send_op(input logic [7:0] sel, input logic [63:0] res,
                           input logic [63:0] sdata, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid      = 1'b1;
        bus.in_alu_sel    = sel;
        bus.in_alu_res    = res;
        bus.in_store_data = sdata;
        bus.in_rd         = rd;
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.in_alu_sel    = 8'hFF;
        bus.in_alu_res    = '1;
        bus.in_store_data = '1;
        bus.in_rd         = 5'h1F;
    endtask

    // Play the memory: check request, stall ready, then answer after rsp_dly cycles (rsp_dly<0: never)
    task automatic serve_req(input int rdy_dly, input logic [63:0] ea, input logic ew,
                             input logic [63:0] ewd, input logic [7:0] ews,
                             input int rsp_dly, input logic [63:0] rdata);
        int n = 0;
        @(negedge clk);
        while (!bus.mem_req_valid && n < 20) begin @(negedge clk); n++; end
        chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("req_addr",  bus.mem_req_addr, ea);
        chk("req_wen",   64'(bus.mem_req_wen), 64'(ew));
        chk("req_wstrb", 64'(bus.mem_req_wstrb), 64'(ews));
        if (ew) chk("req_wdata", bus.mem_req_wdata, ewd);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk("req_hold_valid", 64'(bus.mem_req_valid), 64'd1);
            chk("req_hold_addr",  bus.mem_req_addr, ea);
            chk("req_hold_wstrb", 64'(bus.mem_req_wstrb), 64'(ews));
            if (ew) chk("req_hold_wdata", bus.mem_req_wdata, ewd);
        end
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        chk("req_drop", 64'(bus.mem_req_valid), 64'd0);
        if (rsp_dly >= 0) begin
            repeat (rsp_dly) @(negedge clk);
            @(negedge clk);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = rdata;
            @(posedge clk); #1;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = '1;
        end
    endtask

    // Writeback side: wait for a result, stall out_ready, compare against the scoreboard
    task automatic collect(input int out_dly, input int bound);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.out_valid && n < bound) begin @(negedge clk); n++; end
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_rd",   64'(bus.out_rd), 64'(e.rd));
        chk("out_wen",  64'(bus.out_wen), 64'(e.wen));
        chk("out_err",  64'(bus.out_err), 64'(e.err));
        for (int i = 0; i < out_dly; i++) begin
            @(negedge clk);
            chk("out_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("out_hold_data",  bus.out_data, e.data);
            chk("out_hold_err",   64'(bus.out_err), 64'(e.err));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_single", 64'(bus.out_valid), 64'd0);
        chk("ready_again", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_alu_sel = 8'd0; bus.in_alu_res = 64'd0;
        bus.in_store_data = 64'd0; bus.in_rd = 5'd0; bus.out_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 64'd0;
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_out_data",  bus.out_data, 64'd0);
        chk("rst_out_err",   64'(bus.out_err), 64'd0);
        chk("rst_wstrb",     64'(bus.mem_req_wstrb), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Pass-through ops
        push_exp(64'd7, 5'd5, 1'b1, 1'b0);
        send_op(INST_ADD, 64'd7, 64'd0, 5'd5);
        chk("add_latency", 64'(bus.out_valid), 64'd1);
        chk("add_no_req",  64'(bus.mem_req_valid), 64'd0);
        collect(0, 4);
        push_exp(64'h1234_5678_9ABC_DEF0, 5'd0, 1'b0, 1'b0);
        send_op(INST_ADD, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd0);
        collect(0, 4);

        // Loads
        push_exp(64'hFFFF_FFFF_8765_4321, 5'd3, 1'b1, 1'b0);
        send_op(INST_LW, 64'h8000_0004, 64'd0, 5'd3);
        serve_req(0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 64'h8765_4321_0000_0000);
        collect(0, 10);
        push_exp(64'h0000_0000_8765_4321, 5'd3, 1'b1, 1'b0);
        send_op(INST_LWU, 64'h8000_0004, 64'd0, 5'd3);
        serve_req(0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 1, 64'h8765_4321_0000_0000);
        collect(0, 10);
        push_exp(64'hFFFF_FFFF_FFFF_FF80, 5'd10, 1'b1, 1'b0);
        send_op(INST_LB, 64'h8000_0007, 64'd0, 5'd10);
        serve_req(1, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 64'h8011_2233_4455_6677);
        collect(0, 10);
        push_exp(64'h0000_0000_0000_0080, 5'd10, 1'b1, 1'b0);
        send_op(INST_LBU, 64'h8000_0007, 64'd0, 5'd10);
        serve_req(0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 64'h8011_2233_4455_6677);
        collect(0, 10);
        push_exp(64'hFFFF_FFFF_FFFF_9ABC, 5'd11, 1'b1, 1'b0);
        send_op(INST_LH, 64'h8000_0002, 64'd0, 5'd11);
        serve_req(0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 64'h0000_0000_9ABC_0000);
        collect(0, 10);
        push_exp(64'h0000_0000_0000_7FFF, 5'd12, 1'b1, 1'b0);
        send_op(INST_LHU, 64'h8000_0006, 64'd0, 5'd12);
        serve_req(0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 64'h7FFF_0000_0000_0000);
        collect(0, 10);
        push_exp(64'h0123_4567_89AB_CDEF, 5'd0, 1'b0, 1'b0);
        send_op(INST_LD, 64'h8000_0008, 64'd0, 5'd0);
        serve_req(0, 64'h8000_0008, 1'b0, 64'd0, 8'h00, 2, 64'h0123_4567_89AB_CDEF);
        collect(0, 10);

        // Stores, the first with request and writeback back-pressure
        push_exp(64'd0, 5'd7, 1'b0, 1'b0);
        send_op(INST_SB, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd7);
        serve_req(5, 64'h8000_0000, 1'b1, 64'h0000_0000_AB00_0000, 8'h08, 2, 64'd0);
        collect(3, 10);
        push_exp(64'd0, 5'd8, 1'b0, 1'b0);
        send_op(INST_SH, 64'h8000_0006, 64'h0000_0000_0000_1234, 5'd8);
        serve_req(0, 64'h8000_0000, 1'b1, 64'h1234_0000_0000_0000, 8'hC0, 0, 64'd0);
        collect(0, 10);
        push_exp(64'd0, 5'd9, 1'b0, 1'b0);
        send_op(INST_SW, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 5'd9);
        serve_req(0, 64'h8000_0000, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0, 64'd0);
        collect(0, 10);
        push_exp(64'd0, 5'd9, 1'b0, 1'b0);
        send_op(INST_SD, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd9);
        serve_req(0, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0);
        collect(0, 10);

        // Misaligned accesses never reach the bus
        push_exp(64'd0, 5'd9, 1'b0, 1'b1);
        send_op(INST_LH, 64'h8000_0001, 64'd0, 5'd9);
        chk("mis_lh_no_req", 64'(bus.mem_req_valid), 64'd0);
        chk("mis_lh_latency", 64'(bus.out_valid), 64'd1);
        collect(0, 4);
        push_exp(64'd0, 5'd4, 1'b0, 1'b1);
        send_op(INST_SW, 64'h8000_0006, 64'h55, 5'd4);
        chk("mis_sw_no_req", 64'(bus.mem_req_valid), 64'd0);
        collect(0, 4);
        push_exp(64'd0, 5'd4, 1'b0, 1'b1);
        send_op(INST_LD, 64'h8000_0004, 64'd0, 5'd4);
        chk("mis_ld_no_req", 64'(bus.mem_req_valid), 64'd0);
        collect(0, 4);

        // Stray response while idle
        @(negedge clk); bus.mem_rsp_valid = 1'b1;
        @(posedge clk); #1; bus.mem_rsp_valid = 1'b0;
        chk("stray_rsp_out", 64'(bus.out_valid), 64'd0);
        chk("stray_rsp_rdy", 64'(bus.in_ready), 64'd1);

        // Response timeout, then a late response that must be ignored
        push_exp(64'd0, 5'd4, 1'b0, 1'b1);
        send_op(INST_LD, 64'h8000_0020, 64'd0, 5'd4);
        serve_req(0, 64'h8000_0020, 1'b0, 64'd0, 8'h00, -1, 64'd0);
        repeat (255) @(posedge clk); #1;
        chk("tmo_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("tmo_fires", 64'(bus.out_valid), 64'd1);
        collect(0, 4);
        repeat (42) @(negedge clk);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h1;
        @(posedge clk); #1; bus.mem_rsp_valid = 1'b0;
        chk("late_rsp_out", 64'(bus.out_valid), 64'd0);
        chk("late_rsp_rdy", 64'(bus.in_ready), 64'd1);

        // Reset while a request is pending
        send_op(INST_LD, 64'h8000_0040, 64'd0, 5'd6);
        @(negedge clk);
        chk("abort_req_up", 64'(bus.mem_req_valid), 64'd1);
        rst = 1'b0; #1;
        chk("abort_req_drop", 64'(bus.mem_req_valid), 64'd0);
        chk("abort_req_rdy",  64'(bus.in_ready), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Reset while waiting for the response
        send_op(INST_LW, 64'h8000_0048, 64'd0, 5'd6);
        serve_req(0, 64'h8000_0048, 1'b0, 64'd0, 8'h00, -1, 64'd0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("abort_wait_req", 64'(bus.mem_req_valid), 64'd0);
        chk("abort_wait_out", 64'(bus.out_valid), 64'd0);
        @(negedge clk); bus.mem_rsp_valid = 1'b1;
        @(negedge clk); bus.mem_rsp_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_out", 64'(bus.out_valid), 64'd0);
        push_exp(64'd7, 5'd5, 1'b1, 1'b0);
        send_op(INST_ADD, 64'd7, 64'd0, 5'd5);
        chk("post_rst_latency", 64'(bus.out_valid), 64'd1);
        collect(0, 4);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
